// File: rtl/stopwatch_pkg.sv
// Shared types and defaults for the stopwatch control sequencer.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    SW_IDLE  = 2'd0,
    SW_RUN   = 2'd1,
    SW_PAUSE = 2'd2,
    SW_LAP   = 2'd3
  } sw_state_t;

  localparam int          SW_DEBOUNCE_CYCLES = 20;
  localparam int          SW_TICK_DIV        = 60000;
  localparam logic [15:0] BCD_ZERO           = 16'h0000;

  // The minute prescaler advances only while the stopwatch is counting.
  function automatic logic is_counting(input sw_state_t s);
    return (s == SW_RUN) || (s == SW_LAP);
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_debounce.sv
// Button conditioner: 2-FF synchroniser, stable-level debounce, rising-edge pulse.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic press
);

  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic          level_d;
  logic [CW-1:0] cnt;

  // cnt counts consecutive samples that disagree with the accepted level;
  // the level flips on the DEBOUNCE_CYCLES-th such sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      cnt     <= '0;
    end else begin
      sync1   <= btn_raw;
      sync2   <= sync1;
      level_d <= level;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign press = level & ~level_d;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control sequencer: button events -> IDLE/RUN/PAUSE/LAP FSM,
// datapath command pulses, minute prescaler and lap-freezing display mux.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = SW_DEBOUNCE_CYCLES,
  parameter int TICK_DIV        = SW_TICK_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start_raw,
  input  logic        btn_reset_raw,
  input  logic [15:0] time_in,
  output logic        sw_start_stop,
  output logic        sw_reset,
  output logic        sw_tick,
  output logic [15:0] disp_time,
  output logic        running,
  output logic        lap_active
);

  localparam int            PW         = $clog2(TICK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  sw_state_t     state;
  sw_state_t     state_next;
  logic          start_ev;
  logic          reset_raw_ev;
  logic          reset_ev;
  logic          start_stop_next;
  logic          reset_next;
  logic          tick_next;
  logic          capture;
  logic [PW-1:0] presc;
  logic [PW-1:0] presc_next;
  logic [15:0]   lap_reg;
  logic [15:0]   disp_next;

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_start_raw),
    .press   (start_ev)
  );

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_reset_btn (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_reset_raw),
    .press   (reset_raw_ev)
  );

  // Start has priority: a reset event coinciding with a start event is dropped.
  assign reset_ev = reset_raw_ev & ~start_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= SW_IDLE;
      sw_start_stop <= 1'b0;
      sw_reset      <= 1'b0;
      sw_tick       <= 1'b0;
      presc         <= '0;
      lap_reg       <= BCD_ZERO;
      disp_time     <= BCD_ZERO;
      running       <= 1'b0;
      lap_active    <= 1'b0;
    end else begin
      state         <= state_next;
      sw_start_stop <= start_stop_next;
      sw_reset      <= reset_next;
      sw_tick       <= tick_next;
      presc         <= presc_next;
      if (capture) lap_reg <= time_in;
      disp_time     <= disp_next;
      running       <= is_counting(state_next);
      lap_active    <= (state_next == SW_LAP);
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      SW_IDLE:  if (start_ev) state_next = SW_RUN;
      SW_RUN:   if (start_ev) state_next = SW_PAUSE;
                else if (reset_ev) state_next = SW_LAP;
      SW_LAP:   if (start_ev) state_next = SW_PAUSE;
                else if (reset_ev) state_next = SW_RUN;
      SW_PAUSE: if (start_ev) state_next = SW_RUN;
                else if (reset_ev) state_next = SW_IDLE;
      default:  state_next = SW_IDLE;
    endcase
  end

  always_comb begin
    start_stop_next = start_ev;
    reset_next      = reset_ev && ((state == SW_IDLE) || (state == SW_PAUSE));
    capture         = reset_ev && (state == SW_RUN);
    tick_next       = is_counting(state) && (presc == PRESC_LAST);

    presc_next = presc;
    if (is_counting(state)) begin
      presc_next = tick_next ? '0 : presc + PW'(1);
    end
    if ((state == SW_IDLE) || reset_next) begin
      presc_next = '0;
    end

    // On entry to LAP the captured value equals time_in, so only a stay in LAP
    // needs the frozen register.
    disp_next = ((state == SW_LAP) && (state_next == SW_LAP)) ? lap_reg : time_in;
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Randomised bench for stopwatch_ctrl: reference model feeds a pulse scoreboard.
module tb_stopwatch_ctrl;

  localparam int D  = 4;
  localparam int TD = 5;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_LAP = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        btn_start_raw = 1'b0;
  logic        btn_reset_raw = 1'b0;
  logic [15:0] time_in = 16'h0000;
  logic        sw_start_stop;
  logic        sw_reset;
  logic        sw_tick;
  logic [15:0] disp_time;
  logic        running;
  logic        lap_active;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.DEBOUNCE_CYCLES(D), .TICK_DIV(TD)) dut (
    .clk           (clk),
    .rst           (rst),
    .btn_start_raw (btn_start_raw),
    .btn_reset_raw (btn_reset_raw),
    .time_in       (time_in),
    .sw_start_stop (sw_start_stop),
    .sw_reset      (sw_reset),
    .sw_tick       (sw_tick),
    .disp_time     (disp_time),
    .running       (running),
    .lap_active    (lap_active)
  );

  typedef struct {
    int         cyc;
    logic [2:0] kind;   // {tick, reset, start_stop}
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          st;
  int          pcount;
  logic [15:0] m_disp;
  logic [15:0] m_lap;
  bit          lvl_s, lvl_r, pend_s, pend_r;
  int          run_s, run_r;
  bit          pipe_s[$];
  bit          pipe_r[$];
  bit          rand_time = 1'b0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  task automatic model_reset();
    st = M_IDLE; pcount = 0; m_disp = 16'h0; m_lap = 16'h0;
    lvl_s = 0; lvl_r = 0; pend_s = 0; pend_r = 0; run_s = 0; run_r = 0;
    pipe_s = '{1'b0, 1'b0};
    pipe_r = '{1'b0, 1'b0};
    q.delete();
  endtask

  // A level is accepted after D consecutive samples that disagree with it; returns 1 on a new press.
  function automatic bit deb_step(input bit seen, inout bit lvl, inout int run);
    if (seen != lvl) begin
      run++;
      if (run == D) begin
        lvl = seen;
        run = 0;
        return seen;
      end
    end else begin
      run = 0;
    end
    return 1'b0;
  endfunction

  // Reference model: state, pulses and display after each rising edge.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      model_reset();
    end else begin : step_blk
      bit s, r, seen;
      int nst;
      logic [2:0] k;
      cyc++;
      s = pend_s;
      r = pend_r && !pend_s;
      k = 3'b000;
      k[0] = s;
      k[1] = r && (st == M_IDLE || st == M_PAUSE);
      k[2] = (st == M_RUN || st == M_LAP) && (pcount == TD - 1);
      nst = st;
      case (st)
        M_IDLE:  if (s) nst = M_RUN;
        M_RUN:   if (s) nst = M_PAUSE; else if (r) nst = M_LAP;
        M_LAP:   if (s) nst = M_PAUSE; else if (r) nst = M_RUN;
        default: if (s) nst = M_RUN; else if (r) nst = M_IDLE;
      endcase
      if (st == M_RUN && r) m_lap = time_in;
      if (st == M_RUN || st == M_LAP) pcount = (pcount + 1) % TD;
      if (st == M_IDLE || k[1]) pcount = 0;
      m_disp = (st == M_LAP && nst == M_LAP) ? m_lap : time_in;
      if (k != 3'b000) q.push_back('{cyc, k});
      st = nst;
      pipe_s.push_back(btn_start_raw);
      seen = pipe_s.pop_front();
      pend_s = deb_step(seen, lvl_s, run_s);
      pipe_r.push_back(btn_reset_raw);
      seen = pipe_r.pop_front();
      pend_r = deb_step(seen, lvl_r, run_r);
    end
  end

  // Monitor: match DUT pulses against the scoreboard and check status outputs.
  always @(negedge clk) begin
    if (!rst) begin : mon_blk
      logic [2:0] got;
      got = {sw_tick, sw_reset, sw_start_stop};
      while (q.size() > 0 && q[0].cyc < cyc) begin
        chk("pulse_missed", 32'(3'b000), 32'(q[0].kind));
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].cyc == cyc) begin
        chk("pulse", 32'(got), 32'(q[0].kind));
        void'(q.pop_front());
      end else if (got != 3'b000) begin
        chk("pulse_unexpected", 32'(got), 32'(3'b000));
      end
      chk("running", 32'(running), 32'(st == M_RUN || st == M_LAP));
      chk("lap_active", 32'(lap_active), 32'(st == M_LAP));
      chk("disp_time", 32'(disp_time), 32'(m_disp));
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rand_time) time_in = 16'($urandom);
    end
  endtask

  task automatic set_btn(input bit which, input bit v);
    if (which) btn_reset_raw = v;
    else btn_start_raw = v;
  endtask

  task automatic press(input bit which, input int bounces, input int hold);
    bit cur;
    cur = 1'b0;
    for (int i = 0; i < bounces; i++) begin
      cur = ~cur;
      set_btn(which, cur);
      step($urandom_range(1, 2));
    end
    set_btn(which, 1'b1);
    step(hold);
    cur = 1'b1;
    for (int i = 0; i < bounces; i++) begin
      cur = ~cur;
      set_btn(which, cur);
      step($urandom_range(1, 2));
    end
    set_btn(which, 1'b0);
    step(D + 6);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_pulses"}, 32'({sw_start_stop, sw_reset, sw_tick}), 32'(3'b000));
    chk({name, "_status"}, 32'({running, lap_active}), 32'(2'b00));
    chk({name, "_disp"}, 32'(disp_time), 32'h0000);
  endtask

  task automatic async_reset();
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_rst");
    step(2);
    #2 rst = 1'b0;
    step(2);
  endtask

  initial begin
    model_reset();
    #7 check_reset_outputs("power_on_rst");
    step(3);
    #2 rst = 1'b0;
    step(3);

    // Bounced start press -> RUN, several ticks.
    rand_time = 1'b1;
    press(1'b0, 3, 12);
    step(20);

    // Lap freeze: display holds captured value while time_in advances.
    rand_time = 1'b0;
    time_in = 16'h0012;
    press(1'b1, 2, 10);
    time_in = 16'h0013; step(1);
    time_in = 16'h0014; step(1);
    time_in = 16'h0015; step(2);
    chk("lap_hold", 32'(disp_time), 32'h0012);
    press(1'b1, 1, 10);
    chk("lap_release", 32'(disp_time), 32'h0015);

    // Pause / resume, then reset from PAUSE.
    rand_time = 1'b1;
    press(1'b0, 2, 10);
    step(17);
    press(1'b0, 0, 10);
    step(9);
    press(1'b0, 1, 8);
    press(1'b1, 2, 8);

    // Simultaneous start + reset while running.
    press(1'b0, 0, 8);
    step(3);
    btn_start_raw = 1'b1;
    btn_reset_raw = 1'b1;
    step(10);
    btn_start_raw = 1'b0;
    btn_reset_raw = 1'b0;
    step(D + 6);
    press(1'b1, 0, 8);

    // Long hold: exactly one event.
    press(1'b0, 0, 100);
    step(5);

    // Async reset mid-run.
    async_reset();

    // Random traffic.
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 5) == 0) begin
        btn_start_raw = 1'b1;
        btn_reset_raw = 1'b1;
        step($urandom_range(6, 20));
        btn_start_raw = 1'b0;
        btn_reset_raw = 1'b0;
        step(D + 6);
      end else begin
        press(1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom_range(6, 30));
      end
      step($urandom_range(0, 12));
      if (n == 25) async_reset();
    end

    step(20);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
